// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings, states and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;
    localparam int MD_WIDTH = 32;
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;
    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} md_state_e;
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring divide on magnitudes.
module muldiv_step import muldiv_pkg::*; #(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             is_div_i,
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] wrk_i,
    input  logic [WIDTH:0]   opr_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] wrk_o,
    output logic             q_bit_o
);
    logic [WIDTH+1:0] sum;
    logic [WIDTH+1:0] diff;
    logic [WIDTH:0]   shl;
    always_comb begin
        sum     = {1'b0, acc_i} + (wrk_i[0] ? {1'b0, opr_i} : '0);
        shl     = {acc_i[WIDTH-1:0], wrk_i[WIDTH-1]};
        diff    = {1'b0, shl} - {1'b0, opr_i};
        q_bit_o = is_div_i & ~diff[WIDTH+1];
        acc_o   = is_div_i ? (diff[WIDTH+1] ? shl : diff[WIDTH:0]) : sum[WIDTH+1:1];
        // divide leaves the quotient slot clear; the caller merges q_bit_o
        wrk_o   = is_div_i ? {wrk_i[WIDTH-2:0], 1'b0} : {sum[0], wrk_i[WIDTH-1:1]};
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Runs one step per cycle on magnitudes, fixes signs at the end, then pulses done.
module muldiv_ctrl import muldiv_pkg::*; #(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, wrk_q, wrk_d, wrk_n;
    logic [WIDTH:0]   acc_q, acc_d, acc_n, opr;
    logic             done_q, done_d, dbz_q, dbz_d;
    logic             is_div, sa, sb, b_zero, q_bit;
    logic [WIDTH-1:0] mag_a, mag_b, quo, rem;
    logic [2*WIDTH-1:0] prod;

    assign is_div = op_is_div(op_q);
    assign sa     = op_is_signed(op_q) & a_q[WIDTH-1];
    assign sb     = op_is_signed(op_q) & b_q[WIDTH-1];
    assign b_zero = b_q == '0;
    assign mag_a  = sa ? -a_q : a_q;
    assign mag_b  = sb ? -b_q : b_q;
    assign opr    = {1'b0, is_div ? mag_b : mag_a};
    assign prod   = (sa ^ sb) ? -{acc_q[WIDTH-1:0], wrk_q} : {acc_q[WIDTH-1:0], wrk_q};
    assign quo    = (sa ^ sb) ? -wrk_q : wrk_q;
    assign rem    = sa ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i(is_div),
        .acc_i   (acc_q),
        .wrk_i   (wrk_q),
        .opr_i   (opr),
        .acc_o   (acc_n),
        .wrk_o   (wrk_n),
        .q_bit_o (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            wrk_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            acc_q   <= acc_d;
            wrk_q   <= wrk_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        acc_d   = acc_q;
        wrk_d   = wrk_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    state_d = PREP;
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                end else if (!start) begin
                    hi_d = mthi ? wdata : hi_q;
                    lo_d = mtlo ? wdata : lo_q;
                end
            end
            PREP: begin
                acc_d   = '0;
                wrk_d   = is_div ? mag_a : mag_b;
                cnt_d   = '0;
                state_d = (is_div && b_zero) ? FIX : ITER;
            end
            ITER: begin
                acc_d   = acc_n;
                wrk_d   = wrk_n | WIDTH'(q_bit);
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : ITER;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dbz_d   = is_div && b_zero;
                if (is_div && b_zero) begin
                    hi_d = a_q;
                    lo_d = WIDTH'(DIV0_LO);
                end else if (is_div) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    {hi_d, lo_d} = prod;
                end
            end
            default: state_d = IDLE;
        endcase
        // a squash overrides whatever the current state would have committed
        if (flush && state_q != IDLE) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
            dbz_d   = 1'b0;
        end
    end

    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: randomized and directed checks of muldiv_ctrl against a plain-arithmetic HI/LO model.
module tb_muldiv_ctrl;
    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, flush = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;
    int          checks = 0, errors = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0;

    muldiv_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // {div_by_zero, hi, lo} from the architectural definition of each op
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint unsigned ux = {32'b0, x};
        longint unsigned uy = {32'b0, y};
        logic [63:0] p;
        if (!o[1]) begin
            p = o[0] ? 64'(ux * uy) : 64'(sx * sy);
            return {1'b0, p};
        end
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
        if (o[0]) return {1'b0, 32'(ux % uy), 32'(ux / uy)};
        return {1'b0, 32'(sx % sy), 32'(sx / sy)};
    endfunction

    function automatic logic [31:0] pick();
        int r = $urandom_range(0, 6);
        return r == 0 ? 32'h0 : r == 1 ? 32'h8000_0000 : r == 2 ? 32'hFFFF_FFFF :
               r == 3 ? 32'h1 : r == 4 ? 32'($urandom_range(0, 50)) : $urandom;
    endfunction

    // issues one op and waits for done; cyc = cycles after the issue edge, bc = busy cycles seen
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int cyc, output int bc);
        @(negedge clk); start = 1'b1; op = o; a = x; b = y;
        @(negedge clk); start = 1'b0;
        cyc = 0; bc = 0;
        while (!done && cyc < 100) begin
            if (busy) bc++;
            @(negedge clk); cyc++;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero, hi, lo} !== 67'b0) begin
            errors++; $display("FAIL reset_hold got busy=%b done=%b dbz=%b hi=%h lo=%h want all 0", busy, done, div_by_zero, hi, lo);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero, hi, lo} !== 67'b0) begin
            errors++; $display("FAIL reset_release got busy=%b done=%b dbz=%b hi=%h lo=%h want all 0", busy, done, div_by_zero, hi, lo);
        end
    endtask

    task automatic test_multu();
        int cyc, bc;
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, cyc, bc);
        checks++; if (bc !== 34 || cyc !== 34) begin errors++; $display("FAIL multu_busy got busy=%0d cyc=%0d want 34", bc, cyc); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL multu_hi got %h want 00000001", hi); end
        checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo got %h want fffffffe", lo); end
        checks++; if (done !== 1'b1 || div_by_zero !== 1'b0) begin errors++; $display("FAIL multu_done got done=%b dbz=%b want 1 0", done, div_by_zero); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_pulse got done=%b want 0", done); end
        exp_hi = 32'd1; exp_lo = 32'hFFFF_FFFE;
    endtask

    task automatic test_signed();
        int cyc, bc;
        logic [1:0] o;
        logic [31:0] x, y;
        logic [64:0] m;
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, cyc, bc);
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mult_neg got %h_%h want ffffffff_ffffffeb", hi, lo); end
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, cyc, bc);
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_neg got %h_%h want ffffffff_fffffffd", hi, lo); end
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3)); x = pick(); y = pick();
            m = model(o, x, y);
            run_op(o, x, y, cyc, bc);
            checks++;
            if ({div_by_zero, hi, lo} !== m || bc !== ((o[1] && y == 0) ? 2 : 34)) begin
                errors++; $display("FAIL rand_op%0d op=%0d a=%h b=%h got dbz=%b hi=%h lo=%h busy=%0d want dbz=%b hi=%h lo=%h",
                                   i, o, x, y, div_by_zero, hi, lo, bc, m[64], m[63:32], m[31:0]);
            end
            exp_hi = m[63:32]; exp_lo = m[31:0];
        end
    endtask

    task automatic test_div_zero();
        int cyc, bc;
        run_op(2'b11, 32'd100, 32'd0, cyc, bc);
        checks++; if (bc !== 2 || cyc !== 2) begin errors++; $display("FAIL dbz_busy got busy=%0d cyc=%0d want 2", bc, cyc); end
        checks++; if ({hi, lo} !== {32'd100, 32'hFFFF_FFFF}) begin errors++; $display("FAIL dbz_result got %h_%h want 00000064_ffffffff", hi, lo); end
        checks++; if (div_by_zero !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL dbz_flag got dbz=%b done=%b want 1 1", div_by_zero, done); end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bc);
        checks++; if ({hi, lo} !== {32'h0, 32'h8000_0000}) begin errors++; $display("FAIL div_ovf got %h_%h want 00000000_80000000", hi, lo); end
        checks++; if (div_by_zero !== 1'b0 || bc !== 34) begin errors++; $display("FAIL div_ovf_flag got dbz=%b busy=%0d want 0 34", div_by_zero, bc); end
        exp_hi = 32'h0; exp_lo = 32'h8000_0000;
    endtask

    task automatic test_ignore_start();
        int cyc, busy_after;
        logic [64:0] m;
        m = model(2'b01, 32'h0001_2345, 32'h0000_6789);
        @(negedge clk); start = 1'b1; op = 2'b01; a = 32'h0001_2345; b = 32'h0000_6789;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd0;
        @(negedge clk); start = 1'b0;
        cyc = 6;
        while (!done && cyc < 100) begin @(negedge clk); cyc++; end
        checks++;
        if ({hi, lo} !== m[63:0] || cyc !== 34 || div_by_zero !== 1'b0) begin
            errors++; $display("FAIL ignore_start got hi=%h lo=%h cyc=%0d dbz=%b want hi=%h lo=%h cyc=34 dbz=0", hi, lo, cyc, div_by_zero, m[63:32], m[31:0]);
        end
        busy_after = 0;
        repeat (40) begin @(negedge clk); if (busy) busy_after++; end
        checks++; if (busy_after !== 0) begin errors++; $display("FAIL no_queue got busy cycles=%0d want 0", busy_after); end
        exp_hi = m[63:32]; exp_lo = m[31:0];
    endtask

    task automatic test_flush();
        int dones;
        @(negedge clk); start = 1'b1; op = 2'b01; a = 32'hFFFF_1234; b = 32'h0000_5678;
        @(negedge clk); start = 1'b0;
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_idle got busy=%b done=%b want 0 0", busy, done); end
        dones = 0;
        repeat (40) begin @(negedge clk); if (done) dones++; end
        checks++; if (dones !== 0) begin errors++; $display("FAIL flush_no_done got %0d done pulses want 0", dones); end
        checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL flush_keep got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
        @(negedge clk); start = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start got busy=%b want 0", busy); end
    endtask

    task automatic test_mt();
        int cyc;
        @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
        checks++; if ({hi, lo} !== {2{32'hA5A5_A5A5}}) begin errors++; $display("FAIL mt_both got %h_%h want a5a5a5a5_a5a5a5a5", hi, lo); end
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5; mthi = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk); start = 1'b0; mthi = 1'b0;
        checks++; if (busy !== 1'b1 || hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mthi_vs_start got busy=%b hi=%h want 1 a5a5a5a5", busy, hi); end
        mtlo = 1'b1; wdata = 32'h0000_DEAD;
        @(negedge clk); mtlo = 1'b0;
        checks++; if (lo !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mtlo_busy got lo=%h want a5a5a5a5", lo); end
        cyc = 0;
        while (!done && cyc < 100) begin @(negedge clk); cyc++; end
        checks++; if ({hi, lo} !== {32'd0, 32'd15}) begin errors++; $display("FAIL mt_then_op got %h_%h want 00000000_0000000f", hi, lo); end
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1357_9BDF;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
        exp_hi = 32'h1357_9BDF; exp_lo = 32'h1357_9BDF;
        checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL mt_reload got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(negedge clk); start = 1'b0;
        repeat (21) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero, hi, lo} !== 67'b0) begin
            errors++; $display("FAIL reset_async got busy=%b done=%b dbz=%b hi=%h lo=%h want all 0", busy, done, div_by_zero, hi, lo);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || {hi, lo} !== 64'b0) begin errors++; $display("FAIL reset_after got busy=%b hi=%h lo=%h want 0", busy, hi, lo); end
        exp_hi = '0; exp_lo = '0;
    endtask

    task automatic test_back_to_back();
        localparam int N = 40;
        logic [1:0]  ops[N];
        logic [31:0] xs[N], ys[N];
        logic [64:0] m;
        int cyc;
        for (int i = 0; i < N; i++) begin
            ops[i] = $urandom_range(0, 1) ? 2'b11 : 2'b01;
            xs[i]  = 32'($urandom_range(0, 127));
            ys[i]  = (i % 13 == 5) ? 32'd0 : 32'($urandom_range(0, 127));
        end
        @(negedge clk); start = 1'b1; op = ops[0]; a = xs[0]; b = ys[0];
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < N; i++) begin
            cyc = 0;
            while (!done && cyc < 100) begin @(negedge clk); cyc++; end
            m = model(ops[i], xs[i], ys[i]);
            checks++;
            if ({div_by_zero, hi, lo} !== m || cyc !== ((ops[i][1] && ys[i] == 0) ? 2 : 34)) begin
                errors++; $display("FAIL b2b_op%0d op=%0d a=%0d b=%0d got dbz=%b hi=%h lo=%h cyc=%0d want dbz=%b hi=%h lo=%h",
                                   i, ops[i], xs[i], ys[i], div_by_zero, hi, lo, cyc, m[64], m[63:32], m[31:0]);
            end
            if (i < N - 1) begin
                start = 1'b1; op = ops[i+1]; a = xs[i+1]; b = ys[i+1];
                @(negedge clk); start = 1'b0;
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept%0d got busy=%b want 1", i + 1, busy); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_signed();
        test_div_zero();
        test_ignore_start();
        test_flush();
        test_mt();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer for the pipelined MIPS32 core; it owns the HI/LO register pair beside the main ALU. It accepts MULT/MULTU/DIV/DIVU from the EX stage and runs a 32-step radix-2 shift-add / restoring-divide loop. It raises `busy` so hazard logic can stall dependent MFHI/MFLO, then writes HI/LO and pulses `done`.

## Interface
- `WIDTH`, 32, operand width; the iteration count equals `WIDTH`.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: issue request, sampled only when `busy`=0.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` in WIDTH: rs operand (multiplicand or dividend).
- `b` in WIDTH: rt operand (multiplier or divisor).
- `flush` in 1: abort the in-flight operation (branch or exception squash).
- `mthi` in 1: write HI.
- `mtlo` in 1: write LO.
- `wdata` in WIDTH: data for `mthi`/`mtlo`.
- `busy` out 1: operation in flight; the stall source for MFHI/MFLO.
- `done` out 1: one-cycle pulse after HI/LO update.
- `div_by_zero` out 1: qualified by `done`.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- States are IDLE, PREP, ITER, FIX.
- IDLE → PREP on `start`. The block latches `op`, `a`, `b` and the sign flags.
- PREP takes magnitudes for signed ops. Operands are held as WIDTH+1 bits, so |−2^31| = 2^31 is exact. The step counter is cleared.
- ITER performs one step per cycle for exactly WIDTH cycles, then moves to FIX.
  - Multiply: if the multiplier LSB is set, add the multiplicand to the upper accumulator, then shift the {acc, mplier} pair right by 1.
  - Divide: shift {rem, quot} left by 1 and trial-subtract the divisor. If the result is non-negative, keep the difference and set the quotient bit.
- FIX applies sign correction, then returns to IDLE.
  - Signed product is negated when sign(a)≠sign(b).
  - Quotient is negated when signs differ; remainder takes the sign of the dividend.
  - The 64-bit product goes to {HI,LO}. For divide, LO=quotient and HI=remainder.
- Divide by zero (`b`=0): the loop is skipped, PREP → FIX. Results are LO=32'hFFFFFFFF, HI=`a`, and `div_by_zero`=1 with `done`.
- Signed overflow, −2^31 ÷ −1: LO=32'h80000000, HI=0, with no flag.
- `mthi`/`mtlo` take effect only in IDLE and when `start`=0; otherwise they are ignored.
  - `start` and `mthi` in the same cycle: `start` wins.
  - `mthi` and `mtlo` together: both registers are written.
- `start` while `busy`=1 is ignored; there is no queue.
- `flush` in any non-IDLE state returns to IDLE at the next edge. HI/LO are unchanged, with no `done` and no flag.
- `flush` in the same cycle as `start` in IDLE: the start is dropped.

## Timing
- Reset values: state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0, counter 0.
- Reset mid-operation aborts immediately. There is no partial HI/LO update.
- Edge E0 samples `start`. `busy`=1 from after E0 through the cycle in which FIX completes.
  - Normal op: PREP 1 + ITER 32 + FIX 1 = 34 cycles busy. HI/LO are written at edge E34.
  - `done` is high in the cycle after E34 only.
  - Divide by zero: 2 cycles busy, HI/LO written at E2.
- `busy` is registered. Back-to-back issue is possible: a `start` in the `done` cycle is accepted.
- `hi`/`lo` are direct register outputs. MFHI in the `done` cycle sees the new value.

## Structure
- Shared package `muldiv_pkg` holds:
  - the `op` encodings;
  - the state enum;
  - the `WIDTH` default;
  - the divide-by-zero result constant 32'hFFFFFFFF.
- One natural sub-module: `muldiv_step`, a combinational single iteration. It takes the mode, the WIDTH+1 accumulator pair and the operand, and returns the next pair plus the quotient bit.
- The top level holds the FSM, the counter, the operand/sign latches and HI/LO.

## Test plan
- MULTU a=32'hFFFFFFFF, b=2 → after 34 busy cycles, HI=1, LO=32'hFFFFFFFE, `done` pulse of 1 cycle.
- MULT a=−3, b=7 → HI=32'hFFFFFFFF, LO=32'hFFFFFFEB. DIV a=−7, b=2 → LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIVU a=100, b=0 → `busy` for 2 cycles, LO=32'hFFFFFFFF, HI=100, `div_by_zero`=1 with `done`. DIV −2^31 ÷ −1 → LO=32'h80000000, HI=0.
- MULTU in flight, `flush` at ITER step 10 → IDLE next cycle, HI/LO keep their prior values, no `done`. A `start` pulse mid-op is ignored.
- IDLE: `mthi`=1 and `mtlo`=1 with `wdata`=32'hA5A5A5A5 → both registers = 32'hA5A5A5A5. `mthi` with a simultaneous `start` → HI unchanged by the write.
- `rst_n` low at ITER step 20 → outputs return to reset values asynchronously. Then sweep `a`,`b` over 0..127 for DIVU/MULTU with back-to-back issue, checked against a reference model.
